// File: rtl/gcd_rr_scheduler.sv
// Round-robin arbiter that time-shares one external subtract-loop GCD unit among NREQ requesters.
// Zero operands are answered directly; a watchdog aborts jobs whose done never arrives.
module gcd_rr_scheduler #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 16,
    parameter int MAX_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    gcd_start,
    output logic [WIDTH-1:0]        gcd_a,
    output logic [WIDTH-1:0]        gcd_b,
    input  logic                    gcd_done,
    input  logic [WIDTH-1:0]        gcd_result,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [1:0]              dbg_state
);

    localparam int IDW = $clog2(NREQ);
    localparam int WCW = $clog2(MAX_CYCLES + 1);
    localparam logic [IDW:0]      NREQ_W  = (IDW + 1)'(NREQ);
    localparam logic [WCW-1:0]    MAX_W   = WCW'(MAX_CYCLES);
    localparam logic [WCW-1:0]    TWO_W   = WCW'(2);
    localparam logic [NREQ-1:0]   ONE_LSB = NREQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [WIDTH-1:0] gcd_a_q, gcd_a_d;
    logic [WIDTH-1:0] gcd_b_q, gcd_b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WCW-1:0]   wd_cnt_q, wd_cnt_d;

    logic [IDW:0]     scan_sum;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WCW-1:0]   wait_cyc;

    // Scan upward from the requester after the last grant, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_sum = {1'b0, last_grant_q} + (IDW + 1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign win_a = req_a[int'(win_idx)*WIDTH +: WIDTH];
    assign win_b = req_b[int'(win_idx)*WIDTH +: WIDTH];

    // Handshake: requester i is accepted in the cycle where req_valid[i] && req_ready[i];
    // req_ready is one-hot on the round-robin winner and only offered while IDLE.
    assign req_ready = (state_q == ST_IDLE && win_found) ? (ONE_LSB << win_idx) : '0;

    // wd_cnt_q holds the number of WAIT cycles already completed; wait_cyc is the current one.
    assign wait_cyc = wd_cnt_q + WCW'(1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        gcd_a_d      = gcd_a_q;
        gcd_b_d      = gcd_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        wd_cnt_d     = wd_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gcd_a_d      = win_a;
                    gcd_b_d      = win_b;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    rsp_err_d    = 1'b0;
                    if (win_a == '0) begin
                        rsp_data_d = win_b;
                        state_d    = ST_RESP;
                    end else if (win_b == '0) begin
                        rsp_data_d = win_a;
                        state_d    = ST_RESP;
                    end else begin
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_cnt_d = wait_cyc;
                // Done is masked in the first WAIT cycle so a level left over from the
                // previous job cannot be mistaken for this one; done beats the watchdog.
                if (wait_cyc >= TWO_W && gcd_done) begin
                    rsp_data_d = gcd_result;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (wait_cyc == MAX_W) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_err_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            gcd_a_q      <= '0;
            gcd_b_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP) ? (ONE_LSB << grant_id_q) : '0;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign gcd_start = (state_q == ST_ISSUE);
    assign gcd_a     = gcd_a_q;
    assign gcd_b     = gcd_b_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler: per-requester stimulus queues, a behavioural GCD datapath,
// and a scoreboard fed at each handshake and drained by the response monitor.
module tb_gcd_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int MAXC = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              gcd_start;
  logic [W-1:0]      gcd_a;
  logic [W-1:0]      gcd_b;
  logic              gcd_done;
  logic [W-1:0]      gcd_result;
  logic              busy;
  logic [1:0]        grant_id;
  logic [1:0]        dbg_state;

  gcd_rr_scheduler #(.NREQ(NREQ), .WIDTH(W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- shared state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0]  stim_a_q[NREQ][$];
  logic [W-1:0]  stim_b_q[NREQ][$];
  logic [NREQ-1:0] taken = '0;
  logic [2+1+W-1:0] exp_q[$];    // {id, err, data}
  int            exp_cyc_q[$];
  int            grant_log[$];
  int            model_last = NREQ - 1;
  int            force_delay = -1;
  int            dp_delay_cur = 0;
  int            dp_w = 0;
  bit            dp_run = 1'b0;
  bit            stale_hi = 1'b0;
  int            start_cnt = 0;
  int            exp_start = 0;
  logic [W-1:0]  cur_a = '0;
  logic [W-1:0]  cur_b = '0;
  logic [W-1:0]  last_rsp_data = '0;
  logic          last_rsp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    stim_a_q[i].push_back(a);
    stim_b_q[i].push_back(b);
  endtask

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (rst) begin
          req_valid[i] = 1'b0;
          taken[i] = 1'b0;
        end else begin
          if (taken[i]) begin
            req_valid[i] = 1'b0;
            taken[i] = 1'b0;
          end
          if (!req_valid[i] && stim_a_q[i].size() > 0) begin
            req_a[i*W +: W] = stim_a_q[i].pop_front();
            req_b[i*W +: W] = stim_b_q[i].pop_front();
            req_valid[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- behavioural GCD datapath ----------------
  // dp_w is the WAIT-cycle number of the current job; done rises in WAIT cycle dp_delay_cur.
  initial begin
    gcd_done = 1'b0;
    gcd_result = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp_run = 1'b0;
        dp_w = 0;
      end else if (gcd_start) begin
        dp_run = 1'b1;
        dp_w = 0;
      end else if (dp_run) begin
        dp_w++;
      end
      if (stale_hi && dp_run && dp_w >= 2) stale_hi = 1'b0;
      gcd_done = stale_hi || (dp_run && dp_delay_cur > 0 && dp_w >= dp_delay_cur);
      gcd_result = stale_hi ? 16'hdead : ref_gcd(gcd_a, gcd_b);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    int win;
    int d;
    int k;
    bit err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic [2+1+W-1:0] e;
    int ecyc;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    if (!rst) begin
      if (gcd_start) begin
        start_cnt++;
        chk("gcd_operands", 64'({gcd_a, gcd_b}), 64'({cur_a, cur_b}));
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, required no response (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          oh = NREQ'(1) << e[W+2:W+1];
          chk("rsp_valid", 64'(rsp_valid), 64'(oh));
          chk("rsp_data", 64'(rsp_data), 64'(e[W-1:0]));
          chk("rsp_err", 64'(rsp_err), 64'(e[W]));
          chk("rsp_cycle", 64'(cyc), 64'(ecyc));
          chk("grant_id", 64'(grant_id), 64'(e[W+2:W+1]));
        end
        last_rsp_data = rsp_data;
        last_rsp_err = rsp_err;
      end
      if (req_ready != '0) begin
        win = rr_pick(req_valid, model_last);
        oh = (win >= 0) ? (NREQ'(1) << win) : '0;
        chk("req_ready", 64'(req_ready), 64'(oh));
        chk("busy_when_ready", 64'(busy), 64'(0));
        if ((req_valid & req_ready) != '0 && win >= 0) begin
          a = req_a[win*W +: W];
          b = req_b[win*W +: W];
          model_last = win;
          grant_log.push_back(win);
          taken[win] = 1'b1;
          d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, MAXC + 2));
          dp_delay_cur = d;
          if (a == '0 || b == '0) begin
            data = (a == '0) ? b : a;
            err = 1'b0;
            ecyc = cyc + 1;
          end else begin
            exp_start++;
            cur_a = a;
            cur_b = b;
            if (d >= 1 && d <= MAXC) begin
              k = (d < 2) ? 2 : d;
              err = 1'b0;
              data = ref_gcd(a, b);
            end else begin
              k = MAXC;
              err = 1'b1;
              data = '0;
            end
            ecyc = cyc + 2 + k;
          end
          exp_q.push_back({2'(win), err, data});
          exp_cyc_q.push_back(ecyc);
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++) begin
      if (stim_a_q[i].size() > 0) return 1'b0;
    end
    return (req_valid == '0) && (taken == '0) && (exp_q.size() == 0);
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: timed out after %0d cycles, required all jobs answered", name, n);
    end
  endtask

  task automatic reset_bench();
    for (int i = 0; i < NREQ; i++) begin
      stim_a_q[i].delete();
      stim_b_q[i].delete();
    end
    exp_q.delete();
    exp_cyc_q.delete();
    model_last = NREQ - 1;
  endtask

  function automatic logic [W-1:0] rand_op();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return '0;
    if (r < 7) return W'($urandom_range(1, 400));
    return W'($urandom_range(1, 65535));
  endfunction

  // ---------------- main stimulus ----------------
  int s0;
  int order_a[5] = '{0, 1, 2, 3, 0};
  int order_b[2] = '{1, 3};

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({req_ready, rsp_valid, rsp_err, gcd_start, busy, rsp_data,
                             gcd_a, gcd_b, grant_id, dbg_state}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // single job, done five cycles after start
    force_delay = 5;
    s0 = start_cnt;
    push(0, 16'd48, 16'd18);
    drain("t1", 200);
    chk("t1_starts", 64'(start_cnt - s0), 64'(1));
    chk("t1_data", 64'(last_rsp_data), 64'(6));

    // round-robin order from reset
    @(posedge clk);
    #1 rst = 1'b1;
    reset_bench();
    @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    force_delay = 2;
    push(0, 16'd12, 16'd9);
    push(0, 16'd40, 16'd25);
    push(1, 16'd7, 16'd21);
    push(2, 16'd100, 16'd64);
    push(3, 16'd81, 16'd27);
    drain("t2a", 400);
    chk("t2_order_len", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t2_order", 64'(grant_log[i]), 64'(order_a[i]));
    grant_log.delete();
    push(1, 16'd30, 16'd12);
    push(3, 16'd14, 16'd49);
    drain("t2b", 200);
    chk("t2b_order_len", 64'(grant_log.size()), 64'(2));
    for (int i = 0; i < 2 && i < grant_log.size(); i++) chk("t2b_order", 64'(grant_log[i]), 64'(order_b[i]));

    // zero operands short-circuit
    force_delay = 3;
    s0 = start_cnt;
    push(0, 16'd0, 16'd35);
    drain("t3a", 100);
    chk("t3_zero_a", 64'(last_rsp_data), 64'(35));
    push(2, 16'd0, 16'd0);
    drain("t3b", 100);
    chk("t3_zero_both", 64'(last_rsp_data), 64'(0));
    push(1, 16'd77, 16'd0);
    drain("t3c", 100);
    chk("t3_zero_b", 64'(last_rsp_data), 64'(77));
    chk("t3_no_start", 64'(start_cnt - s0), 64'(0));

    // watchdog and done-vs-timeout boundaries
    force_delay = 0;
    push(3, 16'd12, 16'd8);
    drain("t4", 200);
    chk("t4_err", 64'(last_rsp_err), 64'(1));
    @(negedge clk);
    chk("t4_idle", 64'({dbg_state, busy}), 64'(0));
    force_delay = MAXC;
    push(0, 16'd91, 16'd65);
    drain("t4b", 200);
    chk("t4_done_wins", 64'({last_rsp_err, last_rsp_data}), 64'(13));
    force_delay = 1;
    push(1, 16'd1000, 16'd600);
    drain("t4c", 200);
    force_delay = MAXC + 1;
    push(2, 16'd9, 16'd6);
    drain("t4d", 200);

    // stale done held through ISSUE and WAIT cycle 1
    dp_run = 1'b0;
    stale_hi = 1'b1;
    force_delay = 4;
    push(1, 16'd100, 16'd75);
    drain("t5", 200);
    chk("t5_data", 64'(last_rsp_data), 64'(25));

    // reset in the middle of WAIT
    force_delay = 0;
    push(0, 16'd30, 16'd20);
    repeat (8) @(posedge clk);
    #1;
    chk("t6_busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    reset_bench();
    @(negedge clk);
    @(negedge clk);
    chk("t6_reset_outputs", 64'({req_ready, rsp_valid, rsp_err, gcd_start, busy, rsp_data,
                                  gcd_a, gcd_b, grant_id, dbg_state}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    stale_hi = 1'b1;
    repeat (6) @(posedge clk);
    force_delay = 3;
    push(2, 16'd21, 16'd14);
    drain("t6", 200);
    chk("t6_data", 64'(last_rsp_data), 64'(7));

    // randomized traffic
    force_delay = -1;
    for (int n = 0; n < 40; n++) begin
      push(int'($urandom_range(0, NREQ - 1)), rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    drain("rand", 5000);

    chk("start_count", 64'(start_cnt), 64'(exp_start));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
